// File: rtl/serial_pkg.sv
// Shared constants for the serial pattern generator and detector benches.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int DEF_MAX_LEN    = 8;
    localparam int DEF_GAP_CYCLES = 2;

    localparam logic [3:0] PAT_1101 = 4'b1101;
    localparam logic [3:0] PAT_1111 = 4'b1111;

endpackage

// File: rtl/pattern_shift_reg.sv
// MSB-first pattern holder: load, reload and shift with a bit index.
module pattern_shift_reg #(
    parameter int MAX_LEN = 8,
    parameter int IW      = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load,
    input  logic               reload,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] load_pat,
    input  logic [IW-1:0]      load_top,
    output logic               next_bit,
    output logic               last
);

    logic [MAX_LEN-1:0] pat_q;
    logic [IW-1:0]      top_q;
    logic [IW-1:0]      idx_q;

    // idx_q is the index of the bit currently on the line
    always_comb begin
        next_bit = 1'b0;
        if (load)
            next_bit = load_pat[load_top];
        else if (reload)
            next_bit = pat_q[top_q];
        else
            next_bit = pat_q[idx_q - 1'b1];
    end

    assign last = (idx_q == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pat_q <= '0;
            top_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            pat_q <= load_pat;
            top_q <= load_top;
            idx_q <= load_top;
        end else if (reload) begin
            idx_q <= top_q;
        end else if (shift) begin
            idx_q <= idx_q - 1'b1;
        end
    end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: one-shot or repeating MSB-first
// bursts on w with an idle gap between repeats and abort on Stop.
module serial_pattern_gen
    import serial_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [MAX_LEN-1:0] Pattern,
    input  logic [LW-1:0]      Length,
    input  logic               Repeat,
    input  logic               Stop,
    output logic               w,
    output logic               Valid,
    output logic               Busy,
    output logic               Done,
    output logic [1:0]         CurState
);

    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          rep_q;

    logic [LW-1:0] eff_len;
    logic [IW-1:0] load_top;
    logic          load_en;
    logic          shift_en;
    logic          reload_en;
    logic          next_bit;
    logic          last;

    assign eff_len  = (Length > LEN_MAX) ? LEN_MAX : Length;
    assign load_top = IW'(eff_len - 1'b1);

    assign load_en   = !Reset && (state == IDLE) && Start
                     && (Length != '0);
    assign shift_en  = !Reset && (state == SHIFT) && !Stop && !last;
    assign reload_en = !Reset && (state == GAP) && !Stop
                     && (gap_cnt == GAP_LAST);

    pattern_shift_reg #(
        .MAX_LEN (MAX_LEN),
        .IW      (IW)
    ) u_sreg (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (load_en),
        .reload   (reload_en),
        .shift    (shift_en),
        .load_pat (Pattern),
        .load_top (load_top),
        .next_bit (next_bit),
        .last     (last)
    );

    assign CurState = state;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            w       <= 1'b0;
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            gap_cnt <= '0;
            rep_q   <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        rep_q <= Repeat;
                        w     <= next_bit;
                        Valid <= 1'b1;
                        Busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (Stop) begin
                        w     <= 1'b0;
                        Valid <= 1'b0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else if (last) begin
                        w     <= 1'b0;
                        Valid <= 1'b0;
                        if (rep_q) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        w <= next_bit;
                    end
                end
                GAP: begin
                    if (Stop) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else if (gap_cnt == GAP_LAST) begin
                        w     <= next_bit;
                        Valid <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
